// File: rtl/h_seq_divider_pkg.sv
// Shared definitions for the sequential divider: default word width
// and the FSM state encoding used by h_seq_divider.
package h_seq_divider_pkg;

    // Hack word size
    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/h_seq_divider_sub_step.sv
// h_sub_step: combinational N-bit subtract (a - b) built from a ripple of
// borrow-propagating bit cells.
// Ports:
//   a, b      : N-bit minuend / subtrahend
//   diff      : low N-1 bits of the difference
//   no_borrow : 1 when a >= b
module h_sub_step
    import h_seq_divider_pkg::*;
#(
    parameter int N = DIV_WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-2:0] diff,
    output logic         no_borrow
);

    logic [N:0] bw;

    assign bw[0] = 1'b0;

    // The top difference bit is always 0 whenever the caller keeps the
    // difference (no borrow), so only the borrow-out of the top cell is used.
    for (genvar i = 0; i < N; i++) begin : g_cell
        assign bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
        if (i < N - 1) begin : g_diff
            assign diff[i] = a[i] ^ b[i] ^ bw[i];
        end
    end

    assign no_borrow = ~bw[N];

endmodule

// File: rtl/h_seq_divider.sv
// h_seq_divider: multi-cycle unsigned restoring divider, one quotient bit
// per clock. start/busy/done handshake, no backpressure.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : request; accepted when busy=0
//   dividend, divisor   : operands, sampled on an accepted start
//   busy                : division in progress
//   done                : one-cycle pulse, results valid
//   quotient, remainder : registered results, held until overwritten
//   div_by_zero         : set with done when divisor was 0
module h_seq_divider
    import h_seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_t state;
    div_state_t state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] q_nx;
    logic             accept;

    assign accept = start && (state != DIV_RUN);

    h_sub_step #(
        .N(WIDTH + 1)
    ) u_step (
        .a        ({rem, dvd[WIDTH-1]}),
        .b        ({1'b0, dsr}),
        .diff     (diff),
        .no_borrow(no_borrow)
    );

    // On a failed trial the shifted value is below the divisor, so its
    // top bit is zero and the low WIDTH bits hold it exactly.
    assign rem_nx = no_borrow ? diff : {rem[WIDTH-2:0], dvd[WIDTH-1]};
    assign q_nx   = {dvd[WIDTH-2:0], no_borrow};

    always_comb begin
        state_nx = state;
        unique case (state)
            DIV_IDLE, DIV_DONE: begin
                if (start) begin
                    state_nx = (divisor == '0) ? DIV_DONE : DIV_RUN;
                end else begin
                    state_nx = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                if (cnt == '0) begin
                    state_nx = DIV_DONE;
                end
            end
            default: state_nx = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= DIV_IDLE;
            cnt         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dvd <= dividend;
                dsr <= divisor;
                rem <= '0;
                cnt <= CNT_LAST;
                if (divisor == '0) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == DIV_RUN) begin
                dvd <= q_nx;
                rem <= rem_nx;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    quotient    <= q_nx;
                    remainder   <= rem_nx;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

    assign busy = (state == DIV_RUN);
    assign done = (state == DIV_DONE);

endmodule

// File: tb/tb_h_seq_divider.sv
// Self-checking bench for h_seq_divider: expected results are queued
// on each accepted start and compared when done pulses.
module tb_h_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];

    int n_chk    = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t0       = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    h_seq_divider #(
        .WIDTH(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (done) begin
                exp_t e;
                done_cnt++;
                check("busy_with_done", {31'd0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", {16'd0, quotient}, {16'd0, e.q});
                    check("remainder", {16'd0, remainder}, {16'd0, e.r});
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input bit acc);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (acc) begin
            e.q = (b == 0) ? 16'hFFFF : a / b;
            e.r = (b == 0) ? a : a % b;
            e.z = (b == 0);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (acc) begin
            t0       = cyc - 1;
            busy_cnt = 0;
        end
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, cyc - t0, exp_lat);
    endtask

    initial begin
        int dc;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        step(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", {16'd0, quotient}, 32'd0);
        check("rst_r", {16'd0, remainder}, 32'd0);
        check("rst_z", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        step(1);

        // 100/7 with latency and busy length
        issue(16'd100, 16'd7, 1);
        wait_done("lat_100_7", 17);
        check("busy_len_100_7", busy_cnt, 16);
        step(1);

        issue(16'hFFFF, 16'd1, 1);
        wait_done("lat_ffff_1", 17);
        step(1);
        issue(16'd3, 16'd10, 1);
        wait_done("lat_3_10", 17);
        step(1);
        issue(16'hFFFF, 16'hFFFF, 1);
        wait_done("lat_ffff_ffff", 17);
        step(1);

        // Divide by zero, then a normal op clears the flag
        issue(16'd5, 16'd0, 1);
        wait_done("lat_div0", 1);
        check("div0_busy_len", busy_cnt, 0);
        step(1);
        issue(16'd9, 16'd3, 1);
        wait_done("lat_9_3", 17);
        step(1);

        // Start while busy is ignored
        issue(16'd1000, 16'd9, 1);
        step(3);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        step(1);
        start = 1'b0;
        wait_done("lat_1000_9", 17);
        step(1);

        // Reset mid-operation aborts
        issue(16'd200, 16'd3, 1);
        step(7);
        reset = 1'b1;
        sb.delete();
        step(1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_q", {16'd0, quotient}, 32'd0);
        check("abort_r", {16'd0, remainder}, 32'd0);
        check("abort_z", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        dc    = done_cnt;
        step(25);
        check("abort_no_done", done_cnt, dc);
        issue(16'd42, 16'd6, 1);
        wait_done("lat_42_6", 17);
        step(1);

        // Back-to-back: start held in the DONE cycle
        issue(16'd100, 16'd7, 1);
        wait_done("lat_b2b_1", 17);
        issue(16'd81, 16'd9, 1);
        check("b2b_hold_q", {16'd0, quotient}, 32'd14);
        check("b2b_hold_r", {16'd0, remainder}, 32'd2);
        step(8);
        check("b2b_mid_q", {16'd0, quotient}, 32'd14);
        wait_done("lat_b2b_2", 17);
        step(2);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/h_seq_divider.md
Name: h_seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse of the adder chain: it performs repeated shift-and-subtract at one quotient bit per clock.
- It sits beside the combinational ALU as a co-processor. The CPU or test harness issues a start pulse, waits for done, then reads the quotient and remainder.
- It uses a valid/busy handshake, so there is no backpressure.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits (Hack word size).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled on the rising edge; accepted only when busy=0.
- dividend  input  WIDTH  unsigned dividend; sampled with an accepted start.
- divisor  input  WIDTH  unsigned divisor; sampled with an accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid in that cycle.
- quotient  output  WIDTH  registered quotient; holds until the next accepted start.
- remainder  output  WIDTH  registered remainder; holds until the next accepted start.
- div_by_zero  output  1  set with done when divisor==0; holds with the results.

Behaviour:
- Reset (synchronous, active-high, clk): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset has priority over everything and aborts any operation in flight; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: when start=1 at the edge, latch dividend into a shift register and divisor into a divisor register, and clear the partial remainder.
  - If divisor!=0: go to RUN, counter=WIDTH-1.
  - If divisor==0: go to DONE directly with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- RUN, each edge:
  - Compute trial = {rem[WIDTH-1:0], dvd_msb} - {1'b0, divisor}, with WIDTH+1-bit arithmetic.
  - If no borrow (trial MSB=0): rem<=trial, quotient bit=1. Otherwise rem<=shifted value, quotient bit=0.
  - Shift the dividend/quotient register left one bit.
  - When counter==0, go to DONE; otherwise decrement the counter.
- DONE: done=1 for exactly one cycle. quotient, remainder and div_by_zero are stable from this cycle onward.
  - Next state is IDLE.
  - A start in the DONE cycle is accepted, giving back-to-back operation: DONE→RUN with the same latching as IDLE.
- Timing, with start accepted at the edge ending cycle 0:
  - Normal division: busy=1 in cycles 1..WIDTH, done=1 in cycle WIDTH+1. Latency is WIDTH+1 cycles; for WIDTH=16, done appears in cycle 17.
  - Divide by zero: busy=0 and done=1 in cycle 1.
- busy = (state==RUN). busy and done are never high together.
- start while busy=1 is ignored; no queuing, and the inputs are not sampled.
- Inputs are sampled only at acceptance. Changing dividend/divisor during RUN has no effect.
- Results and div_by_zero are cleared only by reset. They are overwritten in the DONE cycle of the next operation.
- Width rules: partial remainder is WIDTH+1 bits internally; the remainder output is the low WIDTH bits; quotient is always < 2^WIDTH. No overflow is possible for unsigned operands.

Decomposition:
- Shared include header (guarded like the other headers, e.g. hDividerDefs.vh) holds:
  - state encodings DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_DONE=2'd2;
  - the default WIDTH constant.
- One sub-module, h_sub_step: combinational WIDTH+1-bit subtract with borrow-out, built as a ripple of borrow-propagating bit cells. It returns the difference and a no-borrow flag.
- The FSM, counter and shift registers live in h_seq_divider.

Test Plan:
- 100/7: start in cycle 0 → busy cycles 1..16; done in cycle 17 with quotient=14, remainder=2, div_by_zero=0.
- 0xFFFF/1 → quotient=0xFFFF, remainder=0. Also 3/10 → quotient=0, remainder=3. Also 0xFFFF/0xFFFF → quotient=1, remainder=0.
- 5/0 → done in cycle 1, busy never high, quotient=0xFFFF, remainder=5, div_by_zero=1. A following 9/3 clears div_by_zero → quotient=3, remainder=0.
- Start 1000/9, then pulse start with 50/5 in cycle 4 → second request ignored; done in cycle 17 with quotient=111, remainder=1.
- Start 200/3, assert reset in cycle 8 → cycle 9: busy=0, done=0, all outputs 0, and no done pulse follows. Then 42/6 → quotient=7, remainder=0 after 17 cycles.
- Back-to-back: 100/7 then start 81/9 held in the DONE cycle → second done exactly 17 cycles later with quotient=9, remainder=0. The first result is held until then.
